// File: rtl/axil_lfsr_seq_ctrl.sv
// AXI4-Lite master that programs the LFSR peripheral (SEED, TAPS, CTRL=1), streams a requested
// number of DATA reads out on a valid/ready port, then writes CTRL=0 to stop the LFSR.
module axil_lfsr_seq_ctrl #(
   parameter int                            C_M_AXI_ADDR_WIDTH = 32,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
   parameter int                            C_CNT_WIDTH        = 16
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic                            start,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   seed,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   taps,
   input  logic [C_CNT_WIDTH-1:0]          num_samples,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   sample_data,
   output logic                            sample_valid,
   input  logic                            sample_ready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;

   localparam logic [AW-1:0] ADDR_SEED = C_BASE_ADDR;
   localparam logic [AW-1:0] ADDR_TAPS = C_BASE_ADDR + AW'(4);
   localparam logic [AW-1:0] ADDR_CTRL = C_BASE_ADDR + AW'(8);
   localparam logic [AW-1:0] ADDR_DATA = C_BASE_ADDR + AW'(12);

   localparam logic [DW-1:0]          CTRL_ON  = DW'(1);
   localparam logic [DW-1:0]          CTRL_OFF = '0;
   localparam logic [C_CNT_WIDTH-1:0] CNT_ONE  = C_CNT_WIDTH'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_RESP,
      ST_OUT,
      ST_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             wrIdx_q, wrIdx_d;
   logic                   awDone_q, awDone_d;
   logic                   wDone_q, wDone_d;
   logic [DW-1:0]          seed_q, seed_d;
   logic [DW-1:0]          taps_q, taps_d;
   logic [C_CNT_WIDTH-1:0] numSamples_q, numSamples_d;
   logic [C_CNT_WIDTH-1:0] rdCnt_q, rdCnt_d;
   logic [C_CNT_WIDTH-1:0] rdCntNext;
   logic [DW-1:0]          sampleData_q, sampleData_d;
   logic                   error_q, error_d;
   logic                   awHs, wHs;
   logic [AW-1:0]          wrAddr;
   logic [DW-1:0]          wrData;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q      <= ST_IDLE;
         wrIdx_q      <= '0;
         awDone_q     <= 1'b0;
         wDone_q      <= 1'b0;
         seed_q       <= '0;
         taps_q       <= '0;
         numSamples_q <= '0;
         rdCnt_q      <= '0;
         sampleData_q <= '0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wrIdx_q      <= wrIdx_d;
         awDone_q     <= awDone_d;
         wDone_q      <= wDone_d;
         seed_q       <= seed_d;
         taps_q       <= taps_d;
         numSamples_q <= numSamples_d;
         rdCnt_q      <= rdCnt_d;
         sampleData_q <= sampleData_d;
         error_q      <= error_d;
      end
   end

   // Register programming order: SEED, TAPS, CTRL enable, and finally CTRL disable.
   always_comb begin
      wrAddr = ADDR_CTRL;
      wrData = CTRL_OFF;
      case (wrIdx_q)
         2'd0: begin
            wrAddr = ADDR_SEED;
            wrData = seed_q;
         end
         2'd1: begin
            wrAddr = ADDR_TAPS;
            wrData = taps_q;
         end
         2'd2: begin
            wrAddr = ADDR_CTRL;
            wrData = CTRL_ON;
         end
         default: begin
            wrAddr = ADDR_CTRL;
            wrData = CTRL_OFF;
         end
      endcase
   end

   assign awHs      = M_AXI_AWVALID && M_AXI_AWREADY;
   assign wHs       = M_AXI_WVALID && M_AXI_WREADY;
   assign rdCntNext = rdCnt_q + CNT_ONE;

   always_comb begin
      state_d      = state_q;
      wrIdx_d      = wrIdx_q;
      awDone_d     = awDone_q;
      wDone_d      = wDone_q;
      seed_d       = seed_q;
      taps_d       = taps_q;
      numSamples_d = numSamples_q;
      rdCnt_d      = rdCnt_q;
      sampleData_d = sampleData_q;
      error_d      = error_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               seed_d       = seed;
               taps_d       = taps;
               numSamples_d = num_samples;
               error_d      = 1'b0;
               wrIdx_d      = 2'd0;
               rdCnt_d      = '0;
               awDone_d     = 1'b0;
               wDone_d      = 1'b0;
               state_d      = ST_WR_REQ;
            end
         end

         // AW and W complete independently; the done flags remember which one already went.
         ST_WR_REQ: begin
            if ((awDone_q || awHs) && (wDone_q || wHs)) begin
               awDone_d = 1'b0;
               wDone_d  = 1'b0;
               state_d  = ST_WR_RESP;
            end else begin
               awDone_d = awDone_q || awHs;
               wDone_d  = wDone_q || wHs;
            end
         end

         ST_WR_RESP: begin
            if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != 2'b00) begin
                  error_d = 1'b1;
               end
               case (wrIdx_q)
                  2'd0, 2'd1: begin
                     wrIdx_d = wrIdx_q + 2'd1;
                     state_d = ST_WR_REQ;
                  end
                  2'd2: begin
                     if (numSamples_q != '0) begin
                        state_d = ST_RD_REQ;
                     end else begin
                        wrIdx_d = 2'd3;
                        state_d = ST_WR_REQ;
                     end
                  end
                  default: state_d = ST_DONE;
               endcase
            end
         end

         ST_RD_REQ: begin
            if (M_AXI_ARREADY) begin
               state_d = ST_RD_RESP;
            end
         end

         ST_RD_RESP: begin
            if (M_AXI_RVALID) begin
               sampleData_d = M_AXI_RDATA;
               if (M_AXI_RRESP != 2'b00) begin
                  error_d = 1'b1;
               end
               state_d = ST_OUT;
            end
         end

         // Equality compare lets a full-scale count finish without the counter wrapping.
         ST_OUT: begin
            if (sample_ready) begin
               rdCnt_d = rdCntNext;
               if (rdCntNext == numSamples_q) begin
                  wrIdx_d = 2'd3;
                  state_d = ST_WR_REQ;
               end else begin
                  state_d = ST_RD_REQ;
               end
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   assign M_AXI_AWADDR  = wrAddr;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = (state_q == ST_WR_REQ) && !awDone_q;
   assign M_AXI_WDATA   = wrData;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = (state_q == ST_WR_REQ) && !wDone_q;
   assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
   assign M_AXI_ARADDR  = ADDR_DATA;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = (state_q == ST_RD_REQ);
   assign M_AXI_RREADY  = (state_q == ST_RD_RESP);

   assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done         = (state_q == ST_DONE);
   assign error        = error_q;
   assign sample_data  = sampleData_q;
   assign sample_valid = (state_q == ST_OUT);

endmodule

// File: tb/tb_axil_lfsr_seq_ctrl.sv
// Bench for axil_lfsr_seq_ctrl: a randomised AXI4-Lite slave and sample consumer drive the DUT,
// and each run is checked against the register sequence and sample list the controller must produce.
module tb_axil_lfsr_seq_ctrl;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        ACLK;
   logic        ARESET;
   logic        start;
   logic [31:0] seed;
   logic [31:0] taps;
   logic [15:0] num_samples;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;
   logic [31:0] M_AXI_AWADDR;
   logic [2:0]  M_AXI_AWPROT;
   logic        M_AXI_AWVALID;
   logic        M_AXI_AWREADY;
   logic [31:0] M_AXI_WDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_WVALID;
   logic        M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP;
   logic        M_AXI_BVALID;
   logic        M_AXI_BREADY;
   logic [31:0] M_AXI_ARADDR;
   logic [2:0]  M_AXI_ARPROT;
   logic        M_AXI_ARVALID;
   logic        M_AXI_ARREADY;
   logic [31:0] M_AXI_RDATA;
   logic [1:0]  M_AXI_RRESP;
   logic        M_AXI_RVALID;
   logic        M_AXI_RREADY;

   axil_lfsr_seq_ctrl #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_BASE_ADDR(BASE),
      .C_CNT_WIDTH(16)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start), .seed(seed), .taps(taps),
      .num_samples(num_samples), .busy(busy), .done(done), .error(error),
      .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
      .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
      .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
      .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RREADY(M_AXI_RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;

   // Slave / consumer configuration and logs
   int awDelay = 0, wDelay = 0, arDelay = 0;
   int awWait = 0, wWait = 0, arWait = 0;
   int errReadIdx = -1, bErrIdx = -1;
   int rPending = 0, bCnt = 0, readIdx = 0, sampleIdx = 0;
   int stallIdx = -1, stallLen = 0, stallLeft = 0, stallBad = 0, arMaxStall = 0;
   int protBad = 0, doneCnt = 0, busyBad = 0;
   bit bHs = 0, rHs = 0, rHold = 0;
   logic [31:0] stallData;

   logic [31:0] wrAddrQ[$];
   logic [31:0] wrDataQ[$];
   logic [31:0] arAddrQ[$];
   logic [31:0] rdataQ[$];
   logic [31:0] sampQ[$];
   logic        errAtSample[$];

   logic [31:0] expA[4];
   logic [31:0] expD[4];

   int busyDrop = 0, doneInRun = 0;
   bit runTimeout = 0;
   logic busyFirst, startErr;

   // Slave and consumer act on the falling edge; a handshake seen here completes on the next rising edge.
   always @(negedge ACLK) begin
      if (ARESET) begin
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
         M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
         bHs = 0; rHs = 0; rPending = 0; sample_ready = 0;
         awWait = awDelay; wWait = wDelay; arWait = arDelay;
      end else begin
         if (bHs) begin M_AXI_BVALID = 0; bHs = 0; end
         if (!M_AXI_BVALID && wrAddrQ.size() > bCnt && wrDataQ.size() > bCnt) begin
            M_AXI_BVALID = 1;
            M_AXI_BRESP  = (bCnt == bErrIdx) ? 2'b10 : 2'b00;
            bCnt++;
         end
         bHs = M_AXI_BVALID && M_AXI_BREADY;

         if (M_AXI_AWVALID) begin
            if (M_AXI_AWPROT !== 3'b000) protBad++;
            if (awWait > 0) begin M_AXI_AWREADY = 0; awWait--; end
            else begin M_AXI_AWREADY = 1; wrAddrQ.push_back(M_AXI_AWADDR); end
         end else begin
            M_AXI_AWREADY = 0; awWait = awDelay;
         end

         if (M_AXI_WVALID) begin
            if (M_AXI_WSTRB !== 4'hF) protBad++;
            if (wWait > 0) begin M_AXI_WREADY = 0; wWait--; end
            else begin M_AXI_WREADY = 1; wrDataQ.push_back(M_AXI_WDATA); end
         end else begin
            M_AXI_WREADY = 0; wWait = wDelay;
         end

         if (rHs) begin M_AXI_RVALID = 0; rHs = 0; end
         if (!M_AXI_RVALID && rPending > 0 && !rHold) begin
            M_AXI_RVALID = 1;
            M_AXI_RDATA  = $urandom;
            M_AXI_RRESP  = (readIdx == errReadIdx) ? 2'b10 : 2'b00;
            rdataQ.push_back(M_AXI_RDATA);
            readIdx++;
            rPending--;
         end
         rHs = M_AXI_RVALID && M_AXI_RREADY;

         if (M_AXI_ARVALID) begin
            if (M_AXI_ARPROT !== 3'b000) protBad++;
            if (arWait > 0) begin M_AXI_ARREADY = 0; arWait--; end
            else begin M_AXI_ARREADY = 1; arAddrQ.push_back(M_AXI_ARADDR); rPending++; end
         end else begin
            M_AXI_ARREADY = 0; arWait = arDelay;
         end

         sample_ready = 1;
         if (sample_valid) begin
            if (sampleIdx == stallIdx && stallLeft > 0) begin
               sample_ready = 0;
               if (stallLeft == stallLen) stallData = sample_data;
               else if (sample_data !== stallData) stallBad++;
               if (M_AXI_ARVALID) stallBad++;
               if (arAddrQ.size() > arMaxStall) arMaxStall = arAddrQ.size();
               stallLeft--;
            end else begin
               sampQ.push_back(sample_data);
               errAtSample.push_back(error);
               sampleIdx++;
            end
         end

         if (done) begin
            doneCnt++;
            if (busy) busyBad++;
         end
      end
   end

   // Reference model: the four register writes the controller owes for a given seed/taps.
   function automatic void buildModel(input logic [31:0] s, input logic [31:0] t);
      expA[0] = BASE + 32'h0; expD[0] = s;
      expA[1] = BASE + 32'h4; expD[1] = t;
      expA[2] = BASE + 32'h8; expD[2] = 32'h1;
      expA[3] = BASE + 32'h8; expD[3] = 32'h0;
   endfunction

   task automatic clearLogs();
      wrAddrQ.delete(); wrDataQ.delete(); arAddrQ.delete(); rdataQ.delete();
      sampQ.delete(); errAtSample.delete();
      bCnt = 0; readIdx = 0; sampleIdx = 0; stallLeft = stallLen; stallBad = 0;
      arMaxStall = 0; protBad = 0; busyBad = 0;
   endtask

   task automatic runSeq(input logic [31:0] s, input logic [31:0] t, input logic [15:0] n);
      int d0;
      int budget;
      clearLogs();
      d0 = doneCnt;
      busyDrop = 0;
      runTimeout = 0;
      @(negedge ACLK); #1;
      seed = s; taps = t; num_samples = n; start = 1;
      @(negedge ACLK); #1;
      start = 0;
      busyFirst = busy;
      startErr = error;
      budget = 0;
      while (doneCnt == d0 && budget < 4000) begin
         if (!busy) busyDrop++;
         @(negedge ACLK); #1;
         budget++;
      end
      if (doneCnt == d0) runTimeout = 1;
      repeat (3) @(negedge ACLK);
      #1;
      doneInRun = doneCnt - d0;
   endtask

   task automatic test_reset();
      checks++;
      if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
           busy, done, error, sample_valid} !== 9'b0 || sample_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got=%b data=%h want=0", {M_AXI_AWVALID, M_AXI_WVALID,
                  M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, busy, done, error, sample_valid}, sample_data);
      end
      @(negedge ACLK); #1;
      ARESET = 0;
      repeat (3) @(negedge ACLK);
      #1;
      checks++;
      if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, busy, done, sample_valid} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset got=%b want=0",
                  {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, busy, done, sample_valid});
      end
   endtask

   task automatic test_basic();
      awDelay = 0; wDelay = 0; arDelay = 0; stallIdx = -1; stallLen = 0;
      errReadIdx = -1; bErrIdx = -1;
      buildModel(32'hACE1, 32'hB400);
      runSeq(32'hACE1, 32'hB400, 16'd4);
      checks++;
      if (runTimeout !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout got=1 want=0"); end
      checks++;
      if (wrAddrQ.size() != 4 || wrDataQ.size() != 4) begin
         errors++;
         $display("[TB] FAIL basic_wr_count got=%0d/%0d want=4", wrAddrQ.size(), wrDataQ.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wrAddrQ.size() || i >= wrDataQ.size() || wrAddrQ[i] !== expA[i] || wrDataQ[i] !== expD[i]) begin
            errors++;
            $display("[TB] FAIL basic_write%0d want=%h:%h", i, expA[i], expD[i]);
         end
      end
      checks++;
      if (arAddrQ.size() != 4) begin errors++; $display("[TB] FAIL basic_ar_count got=%0d want=4", arAddrQ.size()); end
      foreach (arAddrQ[i]) begin
         checks++;
         if (arAddrQ[i] !== BASE + 32'hC) begin
            errors++; $display("[TB] FAIL basic_araddr%0d got=%h want=%h", i, arAddrQ[i], BASE + 32'hC);
         end
      end
      checks++;
      if (sampQ.size() != 4 || sampQ != rdataQ) begin
         errors++; $display("[TB] FAIL basic_samples got=%0d items want=4 matching slave data", sampQ.size());
      end
      checks++;
      if (doneInRun != 1 || busyBad != 0 || busyDrop != 0 || busyFirst !== 1'b1) begin
         errors++; $display("[TB] FAIL basic_done_busy got=done%0d bb%0d bd%0d bf%b want=1/0/0/1",
                            doneInRun, busyBad, busyDrop, busyFirst);
      end
      checks++;
      if (error !== 1'b0 || protBad != 0) begin
         errors++; $display("[TB] FAIL basic_error_prot got=%b/%0d want=0/0", error, protBad);
      end
   endtask

   task automatic test_wr_skew();
      for (int k = 0; k < 2; k++) begin
         logic [31:0] s, t;
         s = $urandom; t = $urandom;
         awDelay = (k == 0) ? 3 : 0;
         wDelay  = (k == 0) ? 0 : 3;
         buildModel(s, t);
         runSeq(s, t, 16'(k + 1));
         checks++;
         if (runTimeout !== 1'b0 || wrAddrQ.size() != 4 || wrDataQ.size() != 4) begin
            errors++;
            $display("[TB] FAIL skew%0d_count got=to%b aw%0d w%0d want=0/4/4", k, runTimeout,
                     wrAddrQ.size(), wrDataQ.size());
         end else begin
            for (int i = 0; i < 4; i++) begin
               checks++;
               if (wrAddrQ[i] !== expA[i] || wrDataQ[i] !== expD[i]) begin
                  errors++;
                  $display("[TB] FAIL skew%0d_write%0d got=%h:%h want=%h:%h", k, i,
                           wrAddrQ[i], wrDataQ[i], expA[i], expD[i]);
               end
            end
         end
      end
      awDelay = 0; wDelay = 0;
   endtask

   task automatic test_backpressure();
      stallIdx = 1; stallLen = 10;
      runSeq(32'h1234_5678, 32'h8000_0057, 16'd3);
      checks++;
      if (stallBad != 0 || stallLeft != 0) begin
         errors++; $display("[TB] FAIL bp_stall got=bad%0d left%0d want=0/0", stallBad, stallLeft);
      end
      checks++;
      if (arMaxStall != 2 || arAddrQ.size() != 3) begin
         errors++; $display("[TB] FAIL bp_ar_order got=during%0d total%0d want=2/3", arMaxStall, arAddrQ.size());
      end
      checks++;
      if (sampQ.size() != 3 || sampQ != rdataQ || runTimeout) begin
         errors++; $display("[TB] FAIL bp_samples got=%0d want=3", sampQ.size());
      end
      stallIdx = -1; stallLen = 0;
   endtask

   task automatic test_nosamples();
      logic [31:0] s, t;
      s = $urandom; t = $urandom;
      buildModel(s, t);
      runSeq(s, t, 16'd0);
      checks++;
      if (runTimeout || wrAddrQ.size() != 4 || wrDataQ.size() != 4) begin
         errors++; $display("[TB] FAIL zero_count got=%0d want=4", wrAddrQ.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wrAddrQ[i] !== expA[i] || wrDataQ[i] !== expD[i]) begin
               errors++; $display("[TB] FAIL zero_write%0d got=%h:%h want=%h:%h", i,
                                  wrAddrQ[i], wrDataQ[i], expA[i], expD[i]);
            end
         end
      end
      checks++;
      if (arAddrQ.size() != 0 || sampQ.size() != 0) begin
         errors++; $display("[TB] FAIL zero_no_reads got=ar%0d s%0d want=0/0", arAddrQ.size(), sampQ.size());
      end
      checks++;
      if (doneInRun != 1 || busyDrop != 0 || busyFirst !== 1'b1) begin
         errors++; $display("[TB] FAIL zero_busy_done got=done%0d drop%0d want=1/0", doneInRun, busyDrop);
      end
   endtask

   task automatic test_rresp_err();
      errReadIdx = 1;
      buildModel(32'hCAFE, 32'hD008);
      runSeq(32'hCAFE, 32'hD008, 16'd3);
      checks++;
      if (errAtSample.size() != 3 || errAtSample[0] !== 1'b0 || errAtSample[1] !== 1'b1 || error !== 1'b1) begin
         errors++; $display("[TB] FAIL rresp_error got=n%0d end%b want=3 samples, 0 then 1, end 1",
                            errAtSample.size(), error);
      end
      checks++;
      if (sampQ.size() != 3 || sampQ != rdataQ || wrDataQ.size() != 4 || wrDataQ[3] !== 32'h0) begin
         errors++; $display("[TB] FAIL rresp_complete got=s%0d w%0d want=3/4 ending CTRL=0",
                            sampQ.size(), wrDataQ.size());
      end
      errReadIdx = -1;
      runSeq(32'h1, 32'h2, 16'd1);
      checks++;
      if (startErr !== 1'b0 || error !== 1'b0) begin
         errors++; $display("[TB] FAIL rresp_clear got=%b/%b want=0/0", startErr, error);
      end
   endtask

   task automatic test_reset_midrun();
      int budget;
      clearLogs();
      rHold = 1;
      @(negedge ACLK); #1;
      seed = 32'h55; taps = 32'h66; num_samples = 16'd3; start = 1;
      @(negedge ACLK); #1;
      start = 0;
      budget = 0;
      while (!M_AXI_RREADY && budget < 200) begin
         @(negedge ACLK); #1;
         budget++;
      end
      checks++;
      if (!M_AXI_RREADY) begin errors++; $display("[TB] FAIL midrun_reach_rd_resp got=0 want=1"); end
      ARESET = 1;
      @(negedge ACLK); #1;
      checks++;
      if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
           busy, done, sample_valid} !== 8'b0) begin
         errors++; $display("[TB] FAIL midrun_reset got=%b want=0", {M_AXI_AWVALID, M_AXI_WVALID,
                            M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, busy, done, sample_valid});
      end
      ARESET = 0;
      rHold = 0;
      buildModel(32'hBEEF, 32'h1D);
      runSeq(32'hBEEF, 32'h1D, 16'd2);
      checks++;
      if (runTimeout || wrAddrQ.size() != 4 || wrAddrQ[3] !== expA[3] || wrDataQ[3] !== expD[3] ||
          wrDataQ[0] !== expD[0] || sampQ.size() != 2 || sampQ != rdataQ || doneInRun != 1) begin
         errors++; $display("[TB] FAIL midrun_rerun got=w%0d s%0d done%0d want=4/2/1",
                            wrAddrQ.size(), sampQ.size(), doneInRun);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         logic [31:0] s, t;
         int n;
         bit expErr;
         s = $urandom; t = $urandom;
         n = $urandom_range(1, 5);
         awDelay = $urandom_range(0, 3); wDelay = $urandom_range(0, 3); arDelay = $urandom_range(0, 2);
         stallIdx = $urandom_range(0, n - 1); stallLen = $urandom_range(0, 4);
         errReadIdx = $urandom_range(0, 7) - 1;
         bErrIdx = $urandom_range(0, 7) - 1;
         expErr = (errReadIdx >= 0 && errReadIdx < n) || (bErrIdx >= 0 && bErrIdx < 4);
         buildModel(s, t);
         runSeq(s, t, 16'(n));
         checks++;
         if (runTimeout || wrAddrQ.size() != 4 || wrDataQ.size() != 4 ||
             wrAddrQ[0] !== expA[0] || wrDataQ[0] !== expD[0] || wrAddrQ[1] !== expA[1] ||
             wrDataQ[1] !== expD[1] || wrAddrQ[2] !== expA[2] || wrDataQ[2] !== expD[2] ||
             wrAddrQ[3] !== expA[3] || wrDataQ[3] !== expD[3]) begin
            errors++; $display("[TB] FAIL rand%0d_writes got=%0d writes to%b want=4 in order", k,
                               wrAddrQ.size(), runTimeout);
         end
         checks++;
         if (arAddrQ.size() != n || sampQ.size() != n || sampQ != rdataQ || doneInRun != 1) begin
            errors++; $display("[TB] FAIL rand%0d_reads got=ar%0d s%0d done%0d want=%0d/%0d/1", k,
                               arAddrQ.size(), sampQ.size(), doneInRun, n, n);
         end
         checks++;
         if (error !== expErr) begin
            errors++; $display("[TB] FAIL rand%0d_error got=%b want=%b", k, error, expErr);
         end
      end
      awDelay = 0; wDelay = 0; arDelay = 0; stallIdx = -1; stallLen = 0;
      errReadIdx = -1; bErrIdx = -1;
   endtask

   initial begin
      ARESET = 1; start = 0; seed = 0; taps = 0; num_samples = 0; sample_ready = 0;
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      repeat (3) @(negedge ACLK);
      #1;
      test_reset();
      test_basic();
      test_wr_skew();
      test_backpressure();
      test_nosamples();
      test_rresp_err();
      test_reset_midrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axil_lfsr_seq_ctrl.md
Name: axil_lfsr_seq_ctrl

Overview:
AXI4-Lite master controller that sequences the LFSR peripheral without a processor. On a start pulse it programs SEED, TAPS and CTRL, then reads the DATA register a requested number of times. Each read word is delivered on a valid/ready sample stream, and the controller disables the LFSR when the run ends. It sits between local control logic and the LFSR peripheral's S00_AXI slave port.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 32, AXI data width (fixed 32; wstrb all ones)
C_BASE_ADDR, 32'h0000_0000, peripheral base; SEED=+0x0, TAPS=+0x4, CTRL=+0x8, DATA=+0xC
C_CNT_WIDTH, 16, width of sample counter

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous active-high reset
start  in  1  one-cycle run request; ignored unless idle
seed  in  32  value written to SEED; sampled on accepted start
taps  in  32  value written to TAPS; sampled on accepted start
num_samples  in  C_CNT_WIDTH  DATA reads to perform; sampled on accepted start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at run end
error  out  1  sticky; set on any non-OKAY BRESP/RRESP; cleared by next accepted start
sample_data  out  32  read DATA word
sample_valid  out  1  sample_data valid
sample_ready  in  1  consumer accepts sample
M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR/3/1  write address channel (AWPROT=0)
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WVALID  out  32/4/1  write data channel (WSTRB=4'hF)
M_AXI_WREADY  in  1
M_AXI_BRESP/BVALID  in  2/1
M_AXI_BREADY  out  1
M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR/3/1  read address channel (ARPROT=0)
M_AXI_ARREADY  in  1
M_AXI_RDATA/RRESP/RVALID  in  32/2/1
M_AXI_RREADY  out  1

Behaviour:
- Reset: all VALID/READY outputs 0, busy=0, done=0, error=0, sample_valid=0, sample_data=0, counters 0, state IDLE. Reset mid-transaction drops all valids immediately; no completion is attempted.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, OUT, DONE.
- IDLE: start=1 latches seed, taps and num_samples, clears error, sets wr_idx=0, goes to WR_REQ.
- WR_REQ: AWVALID and WVALID asserted together; address/data = wr_idx 0 -> SEED/seed, 1 -> TAPS/taps, 2 -> CTRL/32'h1, 3 -> CTRL/32'h0.
  - Each channel deasserts independently on its own handshake; AW may complete before, after or with W.
  - Once both are done, go to WR_RESP.
  - AWADDR/WDATA stay stable while valid.
- WR_RESP: BREADY=1.
  - On BVALID: BRESP!=0 sets error.
  - wr_idx 0/1 -> increment, back to WR_REQ.
  - wr_idx 2 -> RD_REQ if num_samples!=0, else wr_idx=3 and WR_REQ.
  - wr_idx 3 -> DONE.
- An error does not abort the run; the full sequence always completes, so the LFSR is always disabled.
- RD_REQ: ARVALID=1, ARADDR=BASE+0xC; on ARREADY go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA into sample_data; RRESP!=0 sets error. Go to OUT.
- OUT: sample_valid=1, sample_data held stable.
  - On sample_ready, increment rd_cnt.
  - rd_cnt+1==num_samples -> wr_idx=3, WR_REQ; else RD_REQ.
  - Only one read is outstanding at a time; no new AR is issued until the sample is accepted (backpressure).
- DONE: done=1 for exactly one cycle, busy falls in the same cycle, next state IDLE.
- start while busy is ignored; it is not queued.
- Minimum latency per write is 2 cycles (WR_REQ, WR_RESP) with a zero-wait slave.
- Minimum latency per sample is 3 cycles (RD_REQ, RD_RESP, OUT) with sample_ready held high.
- num_samples = 2^C_CNT_WIDTH-1 must complete without counter wrap; the counter is C_CNT_WIDTH bits and compared for equality.

Test Plan:
- Zero-wait slave; seed=32'hACE1, taps=32'hB400, num_samples=4 -> writes in order 0x0=ACE1, 0x4=B400, 0x8=1; 4 reads of 0xC; then 0xC... write 0x8=0; sample_valid 4 times with slave's RDATA values; done pulses once; error=0.
- Slave with AWREADY 3 cycles late and WREADY immediate (then the reverse) -> each channel's valid drops on its own handshake; exactly one write per register; no duplicate AW or W beat.
- sample_ready held low 10 cycles on the second sample -> sample_data stable, ARVALID stays 0 throughout, third AR issued only after acceptance.
- num_samples=0 -> writes SEED, TAPS, CTRL=1, CTRL=0; no AR at all; done pulses; busy high for the whole sequence.
- Slave returns RRESP=2'b10 on read 2 of 3 -> error=1 after that beat; all 3 samples delivered; CTRL=0 still written; error cleared by the next start.
- ARESET asserted while in RD_RESP -> next cycle all valids, busy and sample_valid are 0; a following start runs a complete sequence normally.
